tx_packet_scheduler: RTL
========================

TX_PACKET_SCHEDULER -- requirements
Module: tx_packet_scheduler

Interface
REQ-001 SHALL have parameter STATUS_PERIOD, default 50000000, meaning clk cycles between automatic status packets (1 s at 50 MHz).
REQ-002 SHALL have parameter HEADER, default 8'hAA, meaning the first byte of every packet.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port ack_req, input, 1, one-cycle pulse requesting an ACK packet.
REQ-006 SHALL have port cmd_req, input, 1, one-cycle pulse requesting a CMD packet carrying cmd_byte.
REQ-007 SHALL have port cmd_byte, input, 8, CMD payload, sampled when cmd_req=1.
REQ-008 SHALL have port status_byte, input, 8, STATUS payload, sampled at grant.
REQ-009 SHALL have port tx_ready, input, 1, UART transmitter can accept a byte.
REQ-010 SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-011 SHALL have port tx_valid, output, 1, tx_data is valid.
REQ-012 SHALL have port busy, output, 1, a packet is in progress.
REQ-013 SHALL have port pkt_done, output, 1, one-cycle pulse when the checksum byte is accepted.
REQ-014 SHALL have port cmd_overrun, output, 1, one-cycle pulse when cmd_req arrives while a CMD is already pending.

Function
REQ-015 Packet format SHALL be 4 bytes: HEADER, type, payload, checksum.
REQ-016 Type codes SHALL be: ACK 8'h01 with payload 8'h55; CMD 8'h02 with payload cmd_byte; STATUS 8'h03 with payload status_byte.
REQ-017 Checksum SHALL be (type + payload) mod 256, 8-bit wrap, with HEADER excluded.
REQ-018 Each source SHALL have a sticky pending bit, set by its request and cleared at grant; if set and clear occur in the same cycle, the pending bit SHALL remain set.
REQ-019 Repeated ack_req pulses while ACK is pending SHALL collapse into one packet, with no error indication.
REQ-020 cmd_req while CMD is pending SHALL keep the first cmd_byte, discard the new byte and pulse cmd_overrun.
REQ-021 The status timer SHALL count 0..STATUS_PERIOD-1 continuously and set STATUS pending at wrap; a wrap while STATUS is already pending SHALL be absorbed.
REQ-022 Arbitration SHALL be fixed priority ACK > CMD > STATUS, evaluated only in IDLE.
REQ-023 FSM states SHALL be IDLE, HDR, TYPE, PAY, CSUM.
REQ-024 In IDLE with any pending source, the FSM SHALL move to HDR on the next edge, latch the type and payload of the winner, and clear that pending bit.
REQ-025 In HDR, TYPE, PAY and CSUM, tx_valid SHALL be 1 with the corresponding byte on tx_data.
REQ-026 Each state SHALL advance on the cycle where tx_valid && tx_ready; tx_data and tx_valid SHALL be held stable while tx_ready=0.
REQ-027 On acceptance in CSUM, the FSM SHALL return to IDLE and pulse pkt_done for that cycle+1, giving at least one idle cycle between packets.
REQ-028 Minimum latency SHALL be: request at cycle N -> HDR byte valid at N+2 with tx_ready held 1 -> pkt_done at N+6.
REQ-029 In IDLE, tx_valid SHALL be 0 and tx_data SHALL be 8'h00.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 Requests arriving during a packet SHALL queue via their pending bits and be arbitrated at the next IDLE.

Reset
REQ-032 Assertion of rst_n=0 SHALL immediately force: state IDLE, all pending bits 0, timer 0, tx_valid 0, tx_data 8'h00, busy 0, pkt_done 0, cmd_overrun 0.
REQ-033 Reset mid-packet SHALL abandon the packet with no completion pulse; the first STATUS packet after reset SHALL be requested STATUS_PERIOD cycles after release.

Structure
REQ-034 A shared package SHALL hold the type codes (ACK, CMD, STATUS), the ACK payload 8'h55, the default HEADER and the FSM state encoding, for reuse by the receive-side parser.
REQ-035 The status timer SHALL be one sub-module, period_tick, with parameter PERIOD, producing a one-cycle tick at wrap; all other logic stays in tx_packet_scheduler.

Verification
REQ-036 ack_req pulse with tx_ready=1 -> bytes AA,01,55,56 on consecutive accepts; pkt_done 4 cycles after HDR.
REQ-037 cmd_req with cmd_byte=8'hF0, tx_ready toggling 1/0 -> bytes AA,02,F0,F2, each held stable through tx_ready=0 cycles.
REQ-038 ack_req, cmd_req (8'h10) and status tick in the same cycle -> packet order ACK, CMD(10,checksum 12), STATUS, with one IDLE cycle between packets.
REQ-039 cmd_req 8'h11 then cmd_req 8'h22 before grant -> one cmd_overrun pulse; CMD packet carries 8'h11; no 8'h22 packet.
REQ-040 STATUS_PERIOD=8, status_byte=8'hFF -> STATUS packet every 8 cycles, checksum 8'h02 (wrap); rst_n pulled low mid-PAY -> tx_valid 0 at once, no pkt_done, next status tick 8 cycles after release.

Source files
------------

// File: rtl/tx_packet_scheduler_pkg.sv
// Shared definitions for the UART packet link: type codes, fixed payloads and FSM encoding.
// Also imported by the receive-side parser.
package tx_packet_scheduler_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] TYPE_ACK       = 8'h01;
    localparam logic [BYTE_W-1:0] TYPE_CMD       = 8'h02;
    localparam logic [BYTE_W-1:0] TYPE_STATUS    = 8'h03;
    localparam logic [BYTE_W-1:0] ACK_PAYLOAD    = 8'h55;
    localparam logic [BYTE_W-1:0] DEFAULT_HEADER = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_TYPE = 3'd2,
        ST_PAY  = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

    // Header is excluded from the checksum; sum wraps at 8 bits.
    function automatic logic [BYTE_W-1:0] pkt_checksum(input logic [BYTE_W-1:0] pkt_type,
                                                       input logic [BYTE_W-1:0] payload);
        return BYTE_W'(pkt_type + payload);
    endfunction

endpackage

// File: rtl/tx_packet_scheduler_period_tick.sv
// Free-running 0..PERIOD-1 counter producing a registered one-cycle tick at each wrap.
module period_tick #(
    parameter int unsigned PERIOD = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    always_comb begin
        wrap  = (cnt_q == CNT_W'(PERIOD - 1));
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_o <= wrap;
        end
    end

endmodule

// File: rtl/tx_packet_scheduler.sv
// Arbitrates ACK/CMD/STATUS requests and serialises 4-byte packets to a UART transmitter.
module tx_packet_scheduler
    import tx_packet_scheduler_pkg::*;
#(
    parameter int unsigned       STATUS_PERIOD = 50000000,
    parameter logic [BYTE_W-1:0] HEADER        = DEFAULT_HEADER
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ack_req,
    input  logic              cmd_req,
    input  logic [BYTE_W-1:0] cmd_byte,
    input  logic [BYTE_W-1:0] status_byte,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              busy,
    output logic              pkt_done,
    output logic              cmd_overrun
);

    state_e            state_q, state_d;
    logic              ack_pend_q, ack_pend_d;
    logic              cmd_pend_q, cmd_pend_d;
    logic              st_pend_q, st_pend_d;
    logic [BYTE_W-1:0] cmd_byte_q, cmd_byte_d;
    logic [BYTE_W-1:0] type_q, type_d;
    logic [BYTE_W-1:0] pay_q, pay_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              pkt_done_q, pkt_done_d;
    logic              cmd_ovr_q, cmd_ovr_d;
    logic              clr_ack, clr_cmd, clr_st;
    logic              accept;
    logic              status_tick;

    period_tick #(
        .PERIOD (STATUS_PERIOD)
    ) u_status_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (status_tick)
    );

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        pay_d      = pay_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        pkt_done_d = 1'b0;
        clr_ack    = 1'b0;
        clr_cmd    = 1'b0;
        clr_st     = 1'b0;
        accept     = tx_valid_q & tx_ready;

        case (state_q)
            ST_IDLE: begin
                if (ack_pend_q) begin
                    clr_ack = 1'b1;
                    type_d  = TYPE_ACK;
                    pay_d   = ACK_PAYLOAD;
                end else if (cmd_pend_q) begin
                    clr_cmd = 1'b1;
                    type_d  = TYPE_CMD;
                    pay_d   = cmd_byte_q;
                end else if (st_pend_q) begin
                    clr_st  = 1'b1;
                    type_d  = TYPE_STATUS;
                    pay_d   = status_byte;
                end
                if (ack_pend_q || cmd_pend_q || st_pend_q) begin
                    state_d    = ST_HDR;
                    tx_data_d  = HEADER;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_HDR: if (accept) begin
                state_d   = ST_TYPE;
                tx_data_d = type_q;
            end
            ST_TYPE: if (accept) begin
                state_d   = ST_PAY;
                tx_data_d = pay_q;
            end
            ST_PAY: if (accept) begin
                state_d   = ST_CSUM;
                tx_data_d = pkt_checksum(type_q, pay_q);
            end
            ST_CSUM: if (accept) begin
                state_d    = ST_IDLE;
                tx_data_d  = '0;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                pkt_done_d = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                tx_data_d  = '0;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

        // A new request wins over a same-cycle grant so nothing is lost.
        ack_pend_d = (ack_pend_q & ~clr_ack) | ack_req;
        cmd_pend_d = (cmd_pend_q & ~clr_cmd) | cmd_req;
        st_pend_d  = (st_pend_q & ~clr_st) | status_tick;
        cmd_ovr_d  = cmd_req & cmd_pend_q & ~clr_cmd;
        cmd_byte_d = (cmd_req && !cmd_ovr_d) ? cmd_byte : cmd_byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ack_pend_q <= 1'b0;
            cmd_pend_q <= 1'b0;
            st_pend_q  <= 1'b0;
            cmd_byte_q <= '0;
            type_q     <= '0;
            pay_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b0;
            cmd_ovr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_pend_q <= ack_pend_d;
            cmd_pend_q <= cmd_pend_d;
            st_pend_q  <= st_pend_d;
            cmd_byte_q <= cmd_byte_d;
            type_q     <= type_d;
            pay_q      <= pay_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            pkt_done_q <= pkt_done_d;
            cmd_ovr_q  <= cmd_ovr_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign pkt_done    = pkt_done_q;
    assign cmd_overrun = cmd_ovr_q;

endmodule
